// File: rtl/mdu_pkg.sv
// mdu_pkg: shared operation/state types and op-decode helpers for mul_div_unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mdu_state_t;

    function automatic logic is_div(input mdu_op_t op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input mdu_op_t op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_signed_rs1(input mdu_op_t op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic is_signed_rs2(input mdu_op_t op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/response valid-ready bundle between the issue stage and mul_div_unit.
interface mdu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    import mdu_pkg::*;

    logic             req_valid;
    logic             req_ready;
    mdu_op_t          req_op;
    logic [XLEN-1:0]  req_rs1;
    logic [XLEN-1:0]  req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_result;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_tag
    );

endinterface

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring divider on unsigned magnitudes.
// Retires two quotient bits per cycle when MDU_DIV_RADIX4_EN is defined, otherwise one.
module mdu_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
`ifdef MDU_DIV_RADIX4_EN
    localparam int ITER = XLEN / 2;
`else
    localparam int ITER = XLEN;
`endif
    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] rq_q, rq_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;

    // {partial remainder, dividend/quotient} shift pair; the partial remainder stays below the divisor.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] rq,
                                                   input logic [XLEN-1:0]   d);
        logic [XLEN-1:0] r;
        logic [XLEN-1:0] q;
        logic [XLEN:0]   trial;
        r     = rq[2*XLEN-1:XLEN];
        q     = rq[XLEN-1:0];
        trial = {r, q[XLEN-1]} - {1'b0, d};
        if (!trial[XLEN])
            return {trial[XLEN-1:0], q[XLEN-2:0], 1'b1};
        else
            return {r[XLEN-2:0], q[XLEN-1], q[XLEN-2:0], 1'b0};
    endfunction

    always_comb begin
        cnt_d = cnt_q;
        rq_d  = rq_q;
        dvs_d = dvs_q;
        if (abort) begin
            cnt_d = '0;
        end else if (start) begin
            cnt_d = CW'(ITER);
            rq_d  = {{XLEN{1'b0}}, dividend};
            dvs_d = divisor;
        end else if (cnt_q != '0) begin
`ifdef MDU_DIV_RADIX4_EN
            rq_d  = div_step(div_step(rq_q, dvs_q), dvs_q);
`else
            rq_d  = div_step(rq_q, dvs_q);
`endif
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            rq_q  <= '0;
            dvs_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rq_q  <= rq_d;
            dvs_q <= dvs_d;
        end
    end

    assign last      = (cnt_q == CW'(1));
    assign quotient  = rq_q[XLEN-1:0];
    assign remainder = rq_q[2*XLEN-1:XLEN];

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: single-issue RV32M/RV64M multiply/divide unit with valid/ready handshakes.
// Define MDU_DIV_RADIX4_EN for a radix-4 divider (XLEN/2+2 cycle divides).
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2,
    parameter int TAG_W   = 5
) (
    input  logic  clk,
    input  logic  rstn,
    mdu_if.slave  mdu,
    input  logic  flush,
    output logic  busy
);
    localparam int MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    mdu_state_t       state_q, state_d;
    mdu_op_t          op_q, op_d;
    logic [XLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic             resp_valid_q, resp_valid_d;

    logic              in_idle, accept, div_start, div_last;
    mdu_op_t           cur_op;
    logic [XLEN-1:0]   cur_rs1, cur_rs2;
    logic              sgn1, sgn2, neg1, neg2;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_result, special_result, fix_result;
    logic [XLEN-1:0]   div_q, div_r;
    logic              div_zero, div_ovf;

    assign in_idle       = (state_q == ST_IDLE);
    assign mdu.req_ready = in_idle && !flush;
    assign accept        = mdu.req_valid && mdu.req_ready;

    // Operands come straight from the request in the accept cycle, from the latches afterwards.
    assign cur_op  = in_idle ? mdu.req_op  : op_q;
    assign cur_rs1 = in_idle ? mdu.req_rs1 : rs1_q;
    assign cur_rs2 = in_idle ? mdu.req_rs2 : rs2_q;
    assign sgn1    = is_signed_rs1(cur_op);
    assign sgn2    = is_signed_rs2(cur_op);
    assign neg1    = sgn1 && cur_rs1[XLEN-1];
    assign neg2    = sgn2 && cur_rs2[XLEN-1];

    assign prod       = {{XLEN{neg1}}, cur_rs1} * {{XLEN{neg2}}, cur_rs2};
    assign mul_result = (cur_op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    assign div_zero = (cur_rs2 == '0);
    assign div_ovf  = sgn1 && (cur_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (cur_rs2 == '1);
    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = is_rem(cur_op) ? cur_rs1 : '1;
        else if (div_ovf)
            special_result = is_rem(cur_op) ? '0 : cur_rs1;
    end

    assign fix_result = is_rem(cur_op) ? (neg1 ? -div_r : div_r)
                                       : ((neg1 ^ neg2) ? -div_q : div_q);

    mdu_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rstn      (rstn),
        .start     (div_start),
        .abort     (flush),
        .dividend  (neg1 ? -cur_rs1 : cur_rs1),
        .divisor   (neg2 ? -cur_rs2 : cur_rs2),
        .last      (div_last),
        .quotient  (div_q),
        .remainder (div_r)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        tag_d     = tag_q;
        mul_cnt_d = mul_cnt_q;
        result_d  = result_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) begin
                op_d  = mdu.req_op;
                rs1_d = mdu.req_rs1;
                rs2_d = mdu.req_rs2;
                tag_d = mdu.req_tag;
                if (!is_div(cur_op)) begin
                    if (MUL_LAT == 1) begin
                        state_d  = ST_DONE;
                        result_d = mul_result;
                    end else begin
                        state_d   = ST_MUL;
                        mul_cnt_d = MCW'(MUL_LAT - 1);
                    end
                end else if (div_zero || div_ovf) begin
                    state_d  = ST_DONE;
                    result_d = special_result;
                end else begin
                    state_d   = ST_DIV;
                    div_start = 1'b1;
                end
            end
            ST_MUL: begin
                mul_cnt_d = mul_cnt_q - MCW'(1);
                if (mul_cnt_q == MCW'(1)) begin
                    state_d  = ST_DONE;
                    result_d = mul_result;
                end
            end
            ST_DIV:  if (div_last) state_d = ST_FIX;
            ST_FIX: begin
                state_d  = ST_DONE;
                result_d = fix_result;
            end
            ST_DONE: if (mdu.resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush) state_d = ST_IDLE;
        resp_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_MUL;
            rs1_q        <= '0;
            rs2_q        <= '0;
            tag_q        <= '0;
            mul_cnt_q    <= '0;
            result_q     <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            tag_q        <= tag_d;
            mul_cnt_q    <= mul_cnt_d;
            result_q     <= result_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign mdu.resp_valid  = resp_valid_q;
    assign mdu.resp_result = result_q;
    assign mdu.resp_tag    = tag_q;
    assign busy            = !in_idle;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table-driven directed checks of mul_div_unit plus backpressure, flush and reset sequences.
module tb_mul_div_unit;
    import mdu_pkg::*;

    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int TAG_W   = 5;
`ifdef MDU_DIV_RADIX4_EN
    localparam int DIV_LAT = XLEN / 2 + 2;
`else
    localparam int DIV_LAT = XLEN + 2;
`endif
    localparam int NV = 20;

    typedef struct {
        mdu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;

    mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    mul_div_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .mdu   (bus),
        .flush (flush),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the response handshake edge.
    task automatic do_op(input string nm, input mdu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t,
                         input logic [31:0] exp, input int lat);
        int n;
        bit seen;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_rs1   = a;
        bus.req_rs2   = b;
        bus.req_tag   = t;
        bus.resp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n <= 200) begin
            if (bus.resp_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1; n++;
            end
        end
        check({nm, " latency"}, 64'(n), 64'(lat));
        check({nm, " result"}, {32'h0, bus.resp_result}, {32'h0, exp});
        check({nm, " tag"}, {59'h0, bus.resp_tag}, {59'h0, t});
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[NV];
        int   n;
        bit   seen;

        vecs[0]  = '{OP_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, MUL_LAT};
        vecs[1]  = '{OP_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT};
        vecs[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, MUL_LAT};
        vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, MUL_LAT};
        vecs[4]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        vecs[5]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT};
        vecs[6]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT};
        vecs[7]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT};
        vecs[8]  = '{OP_DIVU,   32'd100,      32'd7,        32'h0000000E, DIV_LAT};
        vecs[9]  = '{OP_REMU,   32'd100,      32'd7,        32'h00000002, DIV_LAT};
        vecs[10] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT};
        vecs[11] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'h00000001, DIV_LAT};
        vecs[12] = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[13] = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vecs[14] = '{OP_REM,    32'd5,        32'd0,        32'h00000005, 1};
        vecs[15] = '{OP_REMU,   32'd5,        32'd0,        32'h00000005, 1};
        vecs[16] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vecs[17] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        vecs[18] = '{OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, DIV_LAT};
        vecs[19] = '{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, DIV_LAT};

        bus.req_valid  = 1'b0;
        bus.req_op     = OP_MUL;
        bus.req_rs1    = '0;
        bus.req_rs2    = '0;
        bus.req_tag    = '0;
        bus.resp_ready = 1'b1;

        #12;
        check("reset busy", {63'h0, busy}, 64'h0);
        check("reset resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        check("reset req_ready", {63'h0, bus.req_ready}, 64'h1);
        check("reset result", {32'h0, bus.resp_result}, 64'h0);
        check("reset tag", {59'h0, bus.resp_tag}, 64'h0);
        #5 rstn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++)
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  5'(i + 1), vecs[i].exp, vecs[i].lat);

        // Backpressure: response must hold while resp_ready is low.
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_op     = OP_DIVU;
        bus.req_rs1    = 32'd100;
        bus.req_rs2    = 32'd7;
        bus.req_tag    = 5'd9;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.resp_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("bp valid seen", {63'h0, bus.resp_valid}, 64'h1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d valid", c), {63'h0, bus.resp_valid}, 64'h1);
            check($sformatf("bp%0d result", c), {32'h0, bus.resp_result}, 64'hE);
            check($sformatf("bp%0d tag", c), {59'h0, bus.resp_tag}, 64'd9);
            check($sformatf("bp%0d req_ready", c), {63'h0, bus.req_ready}, 64'h0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp after valid", {63'h0, bus.resp_valid}, 64'h0);
        check("bp after req_ready", {63'h0, bus.req_ready}, 64'h1);
        do_op("bp next", OP_REM, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, DIV_LAT);

        // Flush at cycle 10 of a divide.
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV;
        bus.req_rs1   = 32'd1000;
        bus.req_rs2   = 32'd3;
        bus.req_tag   = 5'd21;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1;
        check("flush req_ready low", {63'h0, bus.req_ready}, 64'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flush busy", {63'h0, busy}, 64'h0);
        check("flush req_ready", {63'h0, bus.req_ready}, 64'h1);
        n = 0;
        for (int c = 0; c < 2 * DIV_LAT; c++) begin
            if (bus.resp_valid) n++;
            @(posedge clk); #1;
        end
        check("flush no response", 64'(n), 64'h0);
        do_op("post flush mul", OP_MUL, 32'd3, 32'd4, 5'd22, 32'h0000000C, MUL_LAT);

        // Asynchronous reset in the middle of a divide.
        bus.req_valid = 1'b1;
        bus.req_op    = OP_DIV;
        bus.req_rs1   = 32'd1000;
        bus.req_rs2   = 32'd3;
        bus.req_tag   = 5'd17;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        check("arst busy", {63'h0, busy}, 64'h0);
        check("arst resp_valid", {63'h0, bus.resp_valid}, 64'h0);
        check("arst result", {32'h0, bus.resp_result}, 64'h0);
        check("arst tag", {59'h0, bus.resp_tag}, 64'h0);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        check("arst req_ready", {63'h0, bus.req_ready}, 64'h1);
        seen = bus.resp_valid;
        check("arst no stale resp", {63'h0, seen}, 64'h0);
        do_op("post reset divu", OP_DIVU, 32'd9, 32'd3, 5'd18, 32'h00000003, DIV_LAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
